// File: rtl/vmmu_pixel_fetch.sv
// rtl/vmmu_pixel_fetch.sv - arbiter read client: linear frame fetch into a pixel FIFO for scanout
// Optional: define VMMU_FETCH_STATS_EN to add the DropCount port.
module vmmu_pixel_fetch #(
    parameter int AWIDTH       = 19,
    parameter int DWIDTH       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                          MemClk,
    input  logic                          Reset,
    input  logic                          FrameStart,
    output logic [AWIDTH-1:0]             ReqAddr,
    input  logic [DWIDTH-1:0]             ReqReadData,
    input  logic                          ReadDataRdy,
    input  logic                          PixelReq,
    output logic [DWIDTH-1:0]             PixelData,
    output logic                          PixelValid,
    output logic [$clog2(FIFO_DEPTH):0]   Level,
    output logic                          FetchDone,
    output logic                          Underrun
`ifdef VMMU_FETCH_STATS_EN
    ,
    output logic [15:0]                   DropCount
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(FRAME_PIXELS + 1);

    localparam logic [AWIDTH-1:0] BASE    = AWIDTH'(BASE_ADDR);
    localparam logic [LW-1:0]     DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0]     LAST    = CW'(FRAME_PIXELS - 1);

    logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [CW-1:0]     r_cnt;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_pdata;
    logic              r_pvalid;
    logic              r_done;
    logic              r_underrun;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == DEPTH_L);
    assign w_empty = (r_level == '0);
    // FrameStart wins over any same-cycle read or pop.
    assign w_push  = ReadDataRdy && !r_done && !w_full && !FrameStart;
    assign w_pop   = PixelReq && !w_empty && !FrameStart;

    always_ff @(posedge MemClk) begin
        if (!Reset && w_push) begin
            r_mem[r_wr_ptr] <= ReqReadData;
        end
    end

    always_ff @(posedge MemClk) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_cnt      <= '0;
            r_addr     <= BASE;
            r_pdata    <= '0;
            r_pvalid   <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else if (FrameStart) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_cnt      <= '0;
            r_addr     <= BASE;
            r_pvalid   <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_addr   <= r_addr + 1'b1;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_done <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_pdata  <= r_mem[r_rd_ptr];
            end
            r_pvalid <= w_pop;
            if (PixelReq && w_empty) begin
                r_underrun <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef VMMU_FETCH_STATS_EN
    logic [15:0] r_drop;

    always_ff @(posedge MemClk) begin
        if (Reset || FrameStart) begin
            r_drop <= '0;
        end else if (ReadDataRdy && !r_done && w_full && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    assign DropCount = r_drop;
`endif

    assign ReqAddr    = r_addr;
    assign PixelData  = r_pdata;
    assign PixelValid = r_pvalid;
    assign Level      = r_level;
    assign FetchDone  = r_done;
    assign Underrun   = r_underrun;

endmodule

// File: tb/tb_vmmu_pixel_fetch.sv
// tb/tb_vmmu_pixel_fetch.sv - randomized bench for vmmu_pixel_fetch against a queue-based model
module tb_vmmu_pixel_fetch;

    localparam int AWIDTH = 19;
    localparam int DWIDTH = 8;
    localparam int DEPTH  = 16;
    localparam int BASE   = 0;
    localparam int FRAME  = 40;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              MemClk = 1'b0;
    logic              Reset = 1'b1;
    logic              FrameStart = 1'b0;
    logic [AWIDTH-1:0] ReqAddr;
    logic [DWIDTH-1:0] ReqReadData = '0;
    logic              ReadDataRdy = 1'b0;
    logic              PixelReq = 1'b0;
    logic [DWIDTH-1:0] PixelData;
    logic              PixelValid;
    logic [LW-1:0]     Level;
    logic              FetchDone;
    logic              Underrun;
`ifdef VMMU_FETCH_STATS_EN
    logic [15:0]       DropCount;
`endif

    vmmu_pixel_fetch #(
        .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .FIFO_DEPTH(DEPTH),
        .BASE_ADDR(BASE), .FRAME_PIXELS(FRAME)
    ) dut (
        .MemClk(MemClk), .Reset(Reset), .FrameStart(FrameStart),
        .ReqAddr(ReqAddr), .ReqReadData(ReqReadData), .ReadDataRdy(ReadDataRdy),
        .PixelReq(PixelReq), .PixelData(PixelData), .PixelValid(PixelValid),
        .Level(Level), .FetchDone(FetchDone), .Underrun(Underrun)
`ifdef VMMU_FETCH_STATS_EN
        , .DropCount(DropCount)
`endif
    );

    always #5 MemClk = ~MemClk;

    int total = 0;
    int bad   = 0;
    int pv_cnt = 0;
    bit chk_en = 1'b0;

    logic [DWIDTH-1:0] m_q[$];
    logic [AWIDTH-1:0] m_addr = AWIDTH'(BASE);
    int                m_cnt = 0;
    bit                m_done = 1'b0;
    bit                m_und = 1'b0;
    bit                m_pv = 1'b0;
    logic [DWIDTH-1:0] m_pd = '0;
    int                m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit full_reset);
        m_q.delete();
        m_addr = AWIDTH'(BASE);
        m_cnt  = 0;
        m_done = 1'b0;
        m_und  = 1'b0;
        m_pv   = 1'b0;
        m_drop = 0;
        if (full_reset) m_pd = '0;
    endtask

    task automatic model_update(input bit rst, input bit fs, input bit rdy,
                                input logic [DWIDTH-1:0] data, input bit req);
        int sz;
        if (rst) begin
            model_clear(1'b1);
        end else if (fs) begin
            model_clear(1'b0);
        end else begin
            sz = m_q.size();
            if (rdy && !m_done && sz == DEPTH && m_drop != 16'hFFFF) m_drop++;
            if (req && sz > 0) begin
                m_pd = m_q.pop_front();
                m_pv = 1'b1;
            end else begin
                m_pv = 1'b0;
            end
            if (req && sz == 0) m_und = 1'b1;
            if (rdy && !m_done && sz < DEPTH) begin
                m_q.push_back(data);
                m_addr = m_addr + 1'b1;
                m_cnt++;
                if (m_cnt == FRAME) m_done = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit fs, input bit rdy,
                        input logic [DWIDTH-1:0] data, input bit req);
        Reset       = rst;
        FrameStart  = fs;
        ReadDataRdy = rdy;
        ReqReadData = data;
        PixelReq    = req;
        @(posedge MemClk);
        model_update(rst, fs, rdy, data, req);
        #1;
        if (PixelValid) pv_cnt++;
    endtask

    always @(negedge MemClk) begin
        if (chk_en) begin
            chk("ReqAddr",    32'(ReqAddr),    32'(m_addr));
            chk("PixelValid", 32'(PixelValid), 32'(m_pv));
            chk("PixelData",  32'(PixelData),  32'(m_pd));
            chk("Level",      32'(Level),      32'(m_q.size()));
            chk("FetchDone",  32'(FetchDone),  32'(m_done));
            chk("Underrun",   32'(Underrun),   32'(m_und));
`ifdef VMMU_FETCH_STATS_EN
            chk("DropCount",  32'(DropCount),  32'(m_drop));
`endif
        end
    end

    logic [7:0] lits [4];

    initial begin
        lits = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'h5A, 1);
        chk_en = 1'b1;
        chk("rst ReqAddr", 32'(ReqAddr), 32'd0);
        chk("rst Level", 32'(Level), 32'd0);
        chk("rst PixelValid", 32'(PixelValid), 32'd0);
        chk("rst PixelData", 32'(PixelData), 32'd0);
        chk("rst FetchDone", 32'(FetchDone), 32'd0);
        chk("rst Underrun", 32'(Underrun), 32'd0);

        for (int i = 0; i < 4; i++) step(0, 0, 1, lits[i], 0);
        chk("4push ReqAddr", 32'(ReqAddr), 32'd4);
        chk("4push Level", 32'(Level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 8'h00, 1);
            chk("pop PixelValid", 32'(PixelValid), 32'd1);
            chk("pop PixelData", 32'(PixelData), 32'(lits[i]));
        end
        step(0, 0, 0, 8'h00, 1);
        chk("empty PixelValid", 32'(PixelValid), 32'd0);
        chk("empty PixelData", 32'(PixelData), 32'h44);
        chk("empty Underrun", 32'(Underrun), 32'd1);
        step(0, 0, 1, 8'h77, 0);
        chk("sticky Underrun", 32'(Underrun), 32'd1);

        step(0, 1, 0, 8'h00, 0);
        chk("fs Underrun", 32'(Underrun), 32'd0);
        chk("fs ReqAddr", 32'(ReqAddr), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(i + 1), 0);
        chk("fill Level", 32'(Level), 32'd16);
        step(0, 0, 1, 8'hAA, 1);
        chk("drop ReqAddr", 32'(ReqAddr), 32'd16);
        chk("drop Level", 32'(Level), 32'd15);
        chk("drop pop data", 32'(PixelData), 32'd1);
`ifdef VMMU_FETCH_STATS_EN
        chk("drop DropCount", 32'(DropCount), 32'd1);
`endif
        step(0, 0, 1, 8'hBB, 0);
        chk("refetch ReqAddr", 32'(ReqAddr), 32'd17);
        chk("refetch Level", 32'(Level), 32'd16);

        step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hC0 + i), 0);
        step(0, 0, 1, 8'hC5, 1);
        chk("pushpop Level", 32'(Level), 32'd5);
        chk("pushpop PixelData", 32'(PixelData), 32'hC0);
        step(0, 1, 1, 8'hEE, 1);
        chk("fsmid Level", 32'(Level), 32'd0);
        chk("fsmid ReqAddr", 32'(ReqAddr), 32'd0);
        chk("fsmid FetchDone", 32'(FetchDone), 32'd0);
        chk("fsmid PixelValid", 32'(PixelValid), 32'd0);
        step(0, 0, 0, 8'h00, 0);
        chk("fsmid not stored", 32'(Level), 32'd0);

        pv_cnt = 0;
        for (int i = 0; i < FRAME + 5; i++) step(0, 0, 1, 8'(i), 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        chk("frame FetchDone", 32'(FetchDone), 32'd1);
        chk("frame ReqAddr", 32'(ReqAddr), 32'(FRAME));
        chk("frame pixel count", 32'(pv_cnt), 32'(FRAME));

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 55));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vmmu_pixel_fetch.md
Name: vmmu_pixel_fetch

Overview:
- Read-side client of the video memory slot arbiter.
- Drives one arbiter address source with a linear frame address and accepts each ReadDataRdy/ReqReadData byte into a small pixel FIFO.
- Presents pixels to the scanout side on request.
- Provides flow control by holding the address whenever a delivered byte cannot be stored, so the arbiter's next read slot re-fetches the same byte.

Parameters:
- AWIDTH, 19, address width; matches the arbiter address source width.
- DWIDTH, 8, pixel/data width.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4.
- BASE_ADDR, 0, frame buffer start address.
- FRAME_PIXELS, 307200, bytes fetched per frame (640x480).

Ports:
- MemClk  in  1  memory clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- FrameStart  in  1  one-cycle pulse; restarts the frame fetch.
- ReqAddr  out  AWIDTH  address to the arbiter address source.
- ReqReadData  in  DWIDTH  read data from the arbiter.
- ReadDataRdy  in  1  one-cycle strobe; ReqReadData is valid this cycle.
- PixelReq  in  1  scanout pops one pixel.
- PixelData  out  DWIDTH  popped pixel.
- PixelValid  out  1  PixelData updated this cycle.
- Level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- FetchDone  out  1  all FRAME_PIXELS bytes stored for this frame.
- Underrun  out  1  sticky; a pop was attempted while the FIFO was empty.

Behaviour:
- Reset values: ReqAddr=BASE_ADDR, PixelData=0, PixelValid=0, Level=0, FetchDone=0, Underrun=0. The FIFO pointers and the fetched-byte counter are cleared.
- Reset asserted mid-frame discards all FIFO contents and any pending state. Reset has priority over every other input.
- FrameStart (without Reset) has the same effect as reset, except PixelData keeps its value. FrameStart has priority over a same-cycle ReadDataRdy or PixelReq; both are ignored that cycle.
- Push: a push occurs when ReadDataRdy=1, FetchDone=0 and Level<FIFO_DEPTH (Level sampled at start of cycle). On a push:
  - ReqReadData is written to the FIFO tail;
  - ReqAddr increments by 1, registered, visible the next cycle;
  - the fetched counter increments.
- Dropped read: ReadDataRdy while full causes no push and no address change. The byte is discarded and refetched on a later slot. A same-cycle pop does not free space for the push.
- Ignored read: ReadDataRdy while FetchDone=1 has no effect.
- FetchDone: sets on the cycle after the push that brings the fetched counter to FRAME_PIXELS. ReqAddr then holds at BASE_ADDR+FRAME_PIXELS until FrameStart or Reset.
- Address arithmetic is modulo 2^AWIDTH.
- Pop: PixelReq=1 with Level>0 (start of cycle) pops the head. PixelData and PixelValid=1 appear in the next cycle (1-cycle latency). PixelValid is 1 for exactly one cycle per pop.
- Empty pop: PixelReq with Level=0 causes no pop; PixelValid=0 next cycle, PixelData holds, and Underrun sets. There is no bypass of a same-cycle push.
- Underrun clears only on Reset or FrameStart.
- Simultaneous push and pop with 0<Level<FIFO_DEPTH: both occur and Level is unchanged.
- Level is registered and reflects pushes and pops of the previous cycle.
- Pointers wrap at FIFO_DEPTH.

Optional Feature:
- Macro VMMU_FETCH_STATS_EN.
- When defined, adds output port DropCount (out, 16 bits):
  - counts dropped reads (ReadDataRdy while full and FetchDone=0);
  - saturates at 16'hFFFF;
  - cleared by Reset or FrameStart.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then 4 ReadDataRdy strobes with data 0x11,0x22,0x33,0x44 -> ReqAddr steps 0→4; Level=4; four PixelReq cycles yield PixelData 0x11..0x44 in order, each one cycle after its request.
- Fill to Level=16, then ReadDataRdy with data 0xAA while ReqAddr=16 -> no push; ReqAddr stays 16; DropCount=1 (with macro). After one pop, the next strobe with 0xBB pushes and ReqAddr becomes 17.
- FRAME_PIXELS=8 and continuous popping, 10 strobes -> FetchDone=1 after the 8th push; ReqAddr=8; strobes 9 and 10 are ignored; 8 pixels total are output.
- PixelReq with Level=0 -> PixelValid=0 next cycle; Underrun=1 and stays set through later pushes; FrameStart clears it to 0.
- Level=5 with push and pop in the same cycle -> Level stays 5; popped data is the oldest entry.
- FrameStart mid-frame at ReqAddr=100, Level=7 -> next cycle ReqAddr=BASE_ADDR, Level=0, FetchDone=0; a same-cycle ReadDataRdy is not stored.
